// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state type for the program memory loader
//
// Purpose: loader FSM state encoding, header field positions and memory depth.
// Ports:   none (package).

package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CSUM = 2'd2,
      RESP = 2'd3
   } state_e;

   // Header byte: upper nibble is the start address, lower nibble is count-1.
   localparam int HDR_ADDR_MSB = 7;
   localparam int HDR_ADDR_LSB = 4;
   localparam int HDR_CNT_MSB  = 3;
   localparam int HDR_CNT_LSB  = 0;

   localparam int MEM_DEPTH = 16;

endpackage

// File: rtl/mem_loader_csum.sv
// rtl/mem_loader_csum.sv - running mod-2^WIDTH checksum accumulator
//
// Purpose: accumulates bytes of a frame; the frame is good when the total is zero.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          restart the sum (applied before a same-cycle add)
//   add          add din into the sum
//   din          byte to add
//   is_zero      registered sum equals zero

module mem_loader_csum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             add,
   input  logic [WIDTH-1:0] din,
   output logic             is_zero
);

   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;

   // clr together with add loads din directly, used for the header byte.
   always_comb begin
      sum_d = (clr ? '0 : sum_q) + (add ? din : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign is_zero = (sum_q == '0);

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed byte stream to program RAM write cycles
//
// Purpose: parses header/data/checksum frames and issues one RAM write per data
//          byte, holding the CPU halted (busy) while a frame is in progress.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    byte handshake, in_data is the byte
//   abort                drop the current frame, no response pulse
//   wr_en/wr_addr/wr_data RAM write port, one cycle after each data byte
//   busy                 frame in progress (CPU halt)
//   done / err           one-cycle response: checksum good / bad

module mem_loader
   import mem_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WIDTH-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]  wr_data_q, wr_data_d;
   logic              sum_clr, sum_add, sum_zero;
   logic              xfer;

   assign in_ready = (state_q != RESP);
   assign xfer     = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      sum_clr   = 1'b0;
      sum_add   = 1'b0;

      // abort wins over any byte offered in the same cycle.
      if (abort) begin
         state_d = IDLE;
         rem_d   = '0;
         sum_clr = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (xfer) begin
                  ptr_d   = in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                  rem_d   = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
                  sum_clr = 1'b1;
                  sum_add = 1'b1;
                  state_d = DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = in_data;
                  ptr_d     = ptr_q + PTR_ONE;
                  sum_add   = 1'b1;
                  if (rem_q == '0) begin
                     state_d = CSUM;
                  end else begin
                     rem_d = rem_q - PTR_ONE;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  sum_add = 1'b1;
                  state_d = RESP;
               end
            end
            RESP: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   mem_loader_csum #(
      .WIDTH (WIDTH)
   ) u_csum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (sum_clr),
      .add     (sum_add),
      .din     (in_data),
      .is_zero (sum_zero)
   );

   // RESP holds the final sum, so the response decodes straight from state.
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == RESP) && sum_zero;
   assign err     = (state_q == RESP) && !sum_zero;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader

module tb_mem_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       abort = 1'b0;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       done;
   logic       err;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int n_wr   = 0;
   int n_done = 0;
   int n_err  = 0;
   int w0, d0, e0;

   mem_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .abort    (abort),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (wr_en === 1'b1) n_wr++;
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic snap();
      w0 = n_wr;
      d0 = n_done;
      e0 = n_err;
   endtask

   // Offer one byte; once accepted, check the write (or its absence) one cycle later.
   task automatic send(input logic [7:0] b, input bit is_data, input logic [3:0] exp_addr,
                       input bit gaps);
      int n;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (is_data) begin
         chk("wr_en", {31'd0, wr_en}, 32'd1);
         chk("wr_addr", {28'd0, wr_addr}, {28'd0, exp_addr});
         chk("wr_data", {24'd0, wr_data}, {24'd0, b});
      end else begin
         chk("wr_en_none", {31'd0, wr_en}, 32'd0);
      end
   endtask

   // Called at the negedge right after the checksum byte was taken (RESP cycle).
   task automatic resp_check(input bit good, input int nwr);
      chk("resp_done", {31'd0, done}, {31'd0, good});
      chk("resp_err", {31'd0, err}, {31'd0, !good});
      chk("resp_busy", {31'd0, busy}, 32'd1);
      chk("resp_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("post_done", {31'd0, done}, 32'd0);
      chk("post_err", {31'd0, err}, 32'd0);
      chk("n_writes", n_wr - w0, nwr);
      chk("n_done", n_done - d0, {31'd0, good});
      chk("n_err", n_err - e0, {31'd0, !good});
   endtask

   task automatic basic_frame(input bit gaps);
      snap();
      send(8'h23, 1'b0, 4'd0, gaps);
      chk("hdr_busy", {31'd0, busy}, 32'd1);
      send(8'h11, 1'b1, 4'd2, gaps);
      send(8'h22, 1'b1, 4'd3, gaps);
      send(8'h33, 1'b1, 4'd4, gaps);
      send(8'h44, 1'b1, 4'd5, gaps);
      send(8'h33, 1'b0, 4'd0, gaps);
      resp_check(1'b1, 4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic load, back-to-back
      basic_frame(1'b0);

      // Wrap-around: 14, 15, 0, 1
      snap();
      send(8'hE3, 1'b0, 4'd0, 1'b0);
      send(8'h01, 1'b1, 4'd14, 1'b0);
      send(8'h02, 1'b1, 4'd15, 1'b0);
      send(8'h03, 1'b1, 4'd0, 1'b0);
      send(8'h04, 1'b1, 4'd1, 1'b0);
      send(8'h13, 1'b0, 4'd0, 1'b0);
      resp_check(1'b1, 4);

      // Checksum error: writes still land, err pulses
      snap();
      send(8'hE3, 1'b0, 4'd0, 1'b0);
      send(8'h01, 1'b1, 4'd14, 1'b0);
      send(8'h02, 1'b1, 4'd15, 1'b0);
      send(8'h03, 1'b1, 4'd0, 1'b0);
      send(8'h04, 1'b1, 4'd1, 1'b0);
      send(8'h14, 1'b0, 4'd0, 1'b0);
      resp_check(1'b0, 4);

      // Gaps in in_valid, then a byte offered during RESP becomes the next header
      snap();
      send(8'h23, 1'b0, 4'd0, 1'b1);
      send(8'h11, 1'b1, 4'd2, 1'b1);
      send(8'h22, 1'b1, 4'd3, 1'b1);
      send(8'h33, 1'b1, 4'd4, 1'b1);
      send(8'h44, 1'b1, 4'd5, 1'b1);
      send(8'h33, 1'b0, 4'd0, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'hF0;
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("stall_idle_busy", {31'd0, busy}, 32'd0);
      chk("stall_idle_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_hdr_taken", {31'd0, busy}, 32'd1);
      chk("stall_frame_done", n_done - d0, 32'd1);
      // Single-byte frame: header F0 already taken above
      snap();
      send(8'hAA, 1'b1, 4'd15, 1'b0);
      send(8'h66, 1'b0, 4'd0, 1'b0);
      resp_check(1'b1, 1);

      // Abort after the second data byte
      snap();
      send(8'h23, 1'b0, 4'd0, 1'b0);
      send(8'h11, 1'b1, 4'd2, 1'b0);
      send(8'h22, 1'b1, 4'd3, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h33;
      abort    = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("abort_writes", n_wr - w0, 32'd2);
      chk("abort_done", n_done - d0, 32'd0);
      chk("abort_err", n_err - e0, 32'd0);

      // Asynchronous reset mid-DATA
      snap();
      send(8'h23, 1'b0, 4'd0, 1'b0);
      send(8'h11, 1'b1, 4'd2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("arst_wr_addr", {28'd0, wr_addr}, 32'd0);
      chk("arst_wr_data", {24'd0, wr_data}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);

      // Fresh frame after reset release
      basic_frame(1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
